// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// The package keeps the pipeline-wide name pipeline_types so other stages can import it.
package pipeline_types;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_exception;
        logic [6:0]  exception_cause;
        logic        pre_is_branch;
        logic        pre_taken;
        logic [31:0] pre_branch_addr;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_iq_ram.sv
// Entry storage for inst_queue: two write ports, two read ports, no reset.
// Reads are combinational so the queue head appears without a register stage.
module iq_ram
    import pipeline_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic [1:0]           we,
    input  logic [AW-1:0]        waddr0,
    input  logic [AW-1:0]        waddr1,
    input  iq_entry_t [1:0]      wdata,
    input  logic [AW-1:0]        raddr0,
    input  logic [AW-1:0]        raddr1,
    output iq_entry_t [1:0]      rdata
);

    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr0] <= wdata[0];
        if (we[1]) mem[waddr1] <= wdata[1];
    end

    assign rdata[0] = mem[raddr0];
    assign rdata[1] = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-lane in-order instruction queue between fetch and decode.
// Pointers and counter live here; flush has priority over push and pop.
module inst_queue
    import pipeline_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 pause,
    input  logic [1:0]           push_valid,
    input  iq_entry_t [1:0]      push_entry,
    output logic                 push_ready,
    input  logic [1:0]           pop_req,
    output logic [1:0]           pop_valid,
    output iq_entry_t [1:0]      pop_entry,
    output logic [CNT_W-1:0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    hd;
    logic [AW-1:0]    tl;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] free_slots;
    logic [1:0]       npush;
    logic [1:0]       npop;
    logic             pop0;
    logic             pop1;
    logic [1:0]       we;
    iq_entry_t [1:0]  rdata;

    assign free_slots = CNT_W'(DEPTH) - cnt;
    assign push_ready = (free_slots >= CNT_W'(2));

    // Lane1 alone (2'b10) is not a legal fetch pattern and is ignored.
    always_comb begin
        npush = 2'd0;
        if (push_ready) begin
            case (push_valid)
                2'b01:   npush = 2'd1;
                2'b11:   npush = 2'd2;
                default: npush = 2'd0;
            endcase
        end
    end

    assign we[0] = ~flush & (npush != 2'd0);
    assign we[1] = ~flush & (npush == 2'd2);

    assign pop_valid[0] = (cnt != '0);
    assign pop_valid[1] = (cnt >= CNT_W'(2));

    assign pop0 = pop_req[0] & pop_valid[0] & ~pause;
    assign pop1 = pop_req[1] & pop_valid[1] & pop0;
    assign npop = {1'b0, pop0} + {1'b0, pop1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else if (flush) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            hd  <= hd + AW'(npop);
            tl  <= tl + AW'(npush);
            cnt <= cnt + CNT_W'(npush) - CNT_W'(npop);
        end
    end

    iq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr0 (tl),
        .waddr1 (tl + AW'(1)),
        .wdata  (push_entry),
        .raddr0 (hd),
        .raddr1 (hd + AW'(1)),
        .rdata  (rdata)
    );

    assign pop_entry[0] = pop_valid[0] ? rdata[0] : '0;
    assign pop_entry[1] = pop_valid[1] ? rdata[1] : '0;
    assign count        = cnt;

endmodule

// File: doc/inst_queue.md
# inst_queue

Dual-lane instruction queue between the frontend fetch/predict path and the backend decode stage. It accepts up to two fetched instructions per cycle, each with its PC, fetch exception and branch prediction info, and presents the two oldest entries to the id stage. It decouples fetch bubbles from backend pauses and is emptied on any pipeline flush.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  branch_flush OR exception_flush; empties the queue.
- pause  in  1  backend id/dispatch pause; blocks all pops.
- push_valid  in  2  lane valid bits; bit0 is the older instruction. 2'b10 is illegal and is treated as 2'b00.
- push_entry  in  2×iq_entry_t  fetched entries, lane0 older.
- push_ready  out  1  queue has at least 2 free entries.
- pop_req  in  2  backend wants to consume lane0/lane1 (send_inst_en).
- pop_valid  out  2  bit0: count≥1; bit1: count≥2.
- pop_entry  out  2×iq_entry_t  entry at head and head+1; all-zero when the matching pop_valid bit is 0.
- count  out  CNT_W  current occupancy.

## Operation
- Storage is a circular array with head pointer hd, tail pointer tl (log2(DEPTH) bits, wrap modulo DEPTH) and a counter cnt.
- Push acceptance: npush = push_ready ? (number of valid lanes, per the legal patterns) : 0. Lane0 is written at tl and lane1 at tl+1. tl advances by npush.
- push_ready = (DEPTH − cnt) ≥ 2. It is computed from the registered cnt only; same-cycle pops do not raise it.
- A push with push_ready=0 is dropped. The frontend must hold the push until it is accepted.
- Pop: pop0 = pop_req[0] & pop_valid[0] & ~pause. pop1 = pop_req[1] & pop_valid[1] & pop0. Lane1 never pops without lane0. npop = pop0 + pop1. hd advances by npop.
- Simultaneous push and pop is legal: cnt_next = cnt + npush − npop.
- Flush has priority over push and pop. hd, tl and cnt all go to 0 on the next edge, and that cycle's push and pop are discarded.
- The pop_entry outputs read directly from the array; no register sits after the read.
- No bypass: an entry pushed in cycle N is visible on pop_entry at the earliest in cycle N+1.
- Entries keep their order. The exception and predict fields pass through unmodified.

## Timing
- Reset (rst=0, asynchronous) gives hd=tl=cnt=0, pop_valid=2'b00, pop_entry=0 and push_ready=1. Array contents are not reset.
- Reset asserted mid-operation drops every entry immediately, with no wait for a clock edge.
- Push to pop_valid latency: 1 cycle. Flush to empty: 1 cycle, and push_ready=1 in the cycle after a flush.
- Full (cnt=DEPTH) or cnt=DEPTH−1: push_ready=0. Pops in that cycle still proceed.
- Empty: pop_valid=0 and pop_req is ignored. cnt=1: only lane0 can pop.
- Wrap: when tl=DEPTH−1, a two-lane push writes entries DEPTH−1 and 0. The head read wraps the same way.
- pop_valid and pop_entry are combinational from registered state only. pop_req and pause never feed back into them.

## Structure
- Package pipeline_types receives:
  - iq_entry_t {pc[31:0], inst[31:0], is_exception, exception_cause[6:0], pre_is_branch, pre_taken, pre_branch_addr[31:0]}.
  - IQ_DEPTH = 8.
- Sub-module iq_ram: a DEPTH×iq_entry_t register array with two write ports and two read ports, no reset. Write addresses are tl and tl+1; read addresses are hd and hd+1.
- The pointer, counter and control logic lives in inst_queue.

## Test plan
- Reset, then a two-lane push (pc 0x1c000000 and 0x1c000004):
  - the cycle after the push, pop_valid=2'b11 and the lane0 pc is 0x1c000000;
  - count=2;
  - push_ready=1.
- Fill with four two-lane pushes and no pops. Then:
  - count=8 and push_ready=0;
  - a fifth push is dropped, so count stays 8;
  - a pop of 2 then gives count=6 and push_ready=1.
- Simultaneous push of 2 and pop of 1 at count=3 gives count=4. The popped and remaining pcs stay in program order.
- Wrap case: with tl=7, a two-lane push followed by pops returns the entries in order, and the entry at index 0 reads correctly.
- pause=1 with pop_req=2'b11 at count=2 leaves count=2. pop_req=2'b10 at count=2 pops nothing.
- flush together with push=2'b11 and pop_req=2'b11 at count=5:
  - next cycle count=0, pop_valid=0 and push_ready=1;
  - asserting rst=0 between edges clears pop_valid at once.
